// File: rtl/exp_prng_pkg.sv
// exp_prng_pkg
//   Shared definitions for the exponential-PRNG sample arbiter:
//   - state_e      : arbiter FSM states (warm-up discard / serving requesters)
//   - X_WID_DEF    : default sample width
//   - GRANT_CNT_W  : width of the saturating grant counter
//   - WCNT_W       : width of the warm-up discard counter (covers WARMUP up to 65535)
//   - satInc       : saturating increment used by the grant counter
package exp_prng_pkg;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_SERVE  = 1'b1
  } state_e;

  localparam int X_WID_DEF   = 16;
  localparam int GRANT_CNT_W = 16;
  localparam int WCNT_W      = 16;

  // Counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [GRANT_CNT_W-1:0] satInc(input logic [GRANT_CNT_W-1:0] v);
    return (&v) ? v : v + GRANT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin selector. The search starts at index
//   ptr_i and walks upward modulo NUM_REQ; the first set request wins.
//   Ports:
//     req_i  in  NUM_REQ  request vector (already qualified by the caller)
//     ptr_i  in  PTR_W    index with highest priority this cycle
//     gnt_o  out NUM_REQ  one-hot grant, all zero when req_i == 0
module rr_arbiter
  import exp_prng_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  int   idx;
  logic found;

  // Rotating priority search; the found flag freezes the first hit so later
  // iterations cannot add a second grant bit.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exp_prng_arbiter.sv
// exp_prng_arbiter
//   Shares one exponential-PRNG sample stream among NUM_REQ requesters.
//   After reset or flush the first WARMUP generator samples are discarded;
//   afterwards each accepted sample is parked in a one-entry buffer and
//   handed, unmodified and in order, to exactly one requester chosen
//   round-robin. A grant and a new sample in the same cycle keep the buffer
//   full, so the stream runs at one grant per cycle.
//   Ports:
//     clk_i        in   1        clock, all state on rising edge
//     rst_i        in   1        asynchronous active-high reset
//     smp_i        in   X_WID    generator sample
//     smp_valid_i  in   1        smp_i valid
//     smp_ready_o  out  1        arbiter accepts smp_i this cycle
//     flush_i      in   1        synchronous restart of warm-up
//     req_i        in   NUM_REQ  level requests, held until granted
//     gnt_o        out  NUM_REQ  one-hot grant (completes the transfer)
//     data_o       out  X_WID    granted sample, 0 when no grant
//     busy_o       out  1        high during warm-up
//     grant_cnt_o  out  16       saturating grant count since reset/flush
module exp_prng_arbiter
  import exp_prng_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int X_WID   = X_WID_DEF,
  parameter int WARMUP  = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [X_WID-1:0]       smp_i,
  input  logic                   smp_valid_i,
  output logic                   smp_ready_o,
  input  logic                   flush_i,
  input  logic [NUM_REQ-1:0]     req_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [X_WID-1:0]       data_o,
  output logic                   busy_o,
  output logic [GRANT_CNT_W-1:0] grant_cnt_o
);

  localparam int                PTR_W       = $clog2(NUM_REQ);
  localparam logic [WCNT_W-1:0] WARMUP_LAST = WCNT_W'(WARMUP - 1);

  state_e                 state_q, state_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
  logic [X_WID-1:0]       buf_q, buf_d;
  logic                   bufVld_q, bufVld_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [GRANT_CNT_W-1:0] gcnt_q, gcnt_d;

  logic [NUM_REQ-1:0]     reqEligible;
  logic                   anyGnt;
  logic                   xfer;
  logic [PTR_W-1:0]       ptrAfterGnt;

  // Requests only count while a sample is actually held in SERVE; flush
  // masks them so the flush cycle never grants.
  assign reqEligible = (state_q == ST_SERVE && bufVld_q && !flush_i) ? req_i : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req_i (reqEligible),
    .ptr_i (ptr_q),
    .gnt_o (gnt_o)
  );

  assign anyGnt      = |gnt_o;
  assign data_o      = anyGnt ? buf_q : '0;
  assign busy_o      = (state_q == ST_WARMUP);
  assign grant_cnt_o = gcnt_q;

  // Ready is held low while reset is asserted and on a flush cycle. In SERVE
  // the buffer can take a sample when empty or when it is emptied by a grant
  // in this same cycle.
  always_comb begin
    smp_ready_o = 1'b0;
    if (!rst_i && !flush_i) begin
      if (state_q == ST_WARMUP) begin
        smp_ready_o = 1'b1;
      end else begin
        smp_ready_o = !bufVld_q || anyGnt;
      end
    end
  end

  assign xfer = smp_valid_i && smp_ready_o;

  // Pointer moves to just past the winner, wrapping to 0 after the top index.
  always_comb begin
    ptrAfterGnt = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_o[k]) begin
        ptrAfterGnt = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
      end
    end
  end

  // Next-state logic. Flush overrides everything; otherwise WARMUP counts
  // discarded transfers and SERVE manages the buffer, pointer and counter.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    buf_d    = buf_q;
    bufVld_d = bufVld_q;
    ptr_d    = ptr_q;
    gcnt_d   = gcnt_q;

    if (flush_i) begin
      state_d  = ST_WARMUP;
      wcnt_d   = '0;
      bufVld_d = 1'b0;
      ptr_d    = '0;
      gcnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_WARMUP: begin
          if (xfer) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
            if (wcnt_q == WARMUP_LAST) begin
              state_d = ST_SERVE;
            end
          end
        end
        ST_SERVE: begin
          if (anyGnt) begin
            ptr_d  = ptrAfterGnt;
            gcnt_d = satInc(gcnt_q);
          end
          // A sample arriving with a grant refills the buffer in place.
          if (xfer) begin
            buf_d    = smp_i;
            bufVld_d = 1'b1;
          end else if (anyGnt) begin
            bufVld_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_WARMUP;
        end
      endcase
    end
  end

  // State register with asynchronous reset to an empty, warming-up arbiter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_WARMUP;
      wcnt_q   <= '0;
      buf_q    <= '0;
      bufVld_q <= 1'b0;
      ptr_q    <= '0;
      gcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      buf_q    <= buf_d;
      bufVld_q <= bufVld_d;
      ptr_q    <= ptr_d;
      gcnt_q   <= gcnt_d;
    end
  end

endmodule

// File: doc/exp_prng_arbiter.md
EXP_PRNG_ARBITER -- requirements
Module: exp_prng_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one exponential-PRNG sample stream; legal range 2..8.
REQ-002 Parameter X_WID, default 16: sample width.
REQ-003 Parameter WARMUP, default 64: generator samples discarded after reset or flush; legal range 1..65535.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 smp_i  in  X_WID  sample from exp PRNG generator.
REQ-007 smp_valid_i  in  1  smp_i valid this cycle.
REQ-008 smp_ready_o  out  1  arbiter accepts smp_i this cycle; transfer = smp_valid_i & smp_ready_o.
REQ-009 flush_i  in  1  synchronous restart of warm-up.
REQ-010 req_i  in  NUM_REQ  per-requester sample request, level, held until granted.
REQ-011 gnt_o  out  NUM_REQ  one-hot grant, at most one bit set; a grant completes the transfer that cycle.
REQ-012 data_o  out  X_WID  granted sample; 0 when gnt_o == 0.
REQ-013 busy_o  out  1  high while in WARMUP.
REQ-014 grant_cnt_o  out  16  total grants since reset/flush, saturating at 16'hFFFF.

Function
REQ-015 FSM states: WARMUP, SERVE.
- WARMUP: smp_ready_o=1, accepted samples discarded, warm-up counter +1 per transfer.
- WARMUP -> SERVE on the transfer that brings the counter to WARMUP.
- SERVE -> WARMUP only on flush_i.
REQ-016 SERVE uses a one-entry holding register buf with flag buf_vld.
REQ-017 In SERVE, smp_ready_o = !buf_vld | (gnt_o != 0); combinational.
REQ-018 gnt_o and data_o are combinational from state, buf_vld, buf, req_i and round-robin pointer ptr; nonzero only in SERVE with buf_vld=1 and req_i != 0.
REQ-019 Winner is the first set req_i bit at index ptr, ptr+1, ... modulo NUM_REQ; data_o = buf.
REQ-020 On a grant to index k, ptr <= (k+1) mod NUM_REQ; wrap NUM_REQ-1 -> 0; with no grant, ptr holds.
REQ-021 Grant and new sample in the same cycle: buf is reloaded from smp_i and buf_vld stays 1, giving one grant per cycle at full rate.
REQ-022 Grant without new sample: buf_vld <= 0. Sample with buf empty: buf <= smp_i, buf_vld <= 1.
REQ-023 No request pending: buf and ptr are held, and smp_ready_o=0 while buf is full.
REQ-024 A req_i bit dropping before its grant is legal; that requester is no longer eligible.
REQ-025 flush_i=1 has priority over all other activity:
- gnt_o forced 0 that cycle, smp_ready_o forced 0 that cycle.
- Next state WARMUP; warm-up counter, buf_vld, grant_cnt_o and ptr all cleared.
REQ-026 grant_cnt_o increments by 1 per cycle with gnt_o != 0 and saturates.
REQ-027 Sample values are never modified or reordered; each accepted SERVE sample is granted exactly once.

Reset
REQ-028 rst_i=1 asynchronously sets: state WARMUP, warm-up counter 0, buf_vld 0, buf 0, ptr 0, grant_cnt_o 0.
REQ-029 During reset: gnt_o=0, data_o=0, busy_o=1, smp_ready_o=0.
REQ-030 The first accepted sample is the one on the first clock edge after rst_i deasserts with smp_valid_i=1.

Structure
REQ-031 Shared package exp_prng_pkg holds the FSM state enum, the X_WID default and the grant-counter width constant (16).
REQ-032 Round-robin selection is one combinational sub-module rr_arbiter: inputs req and ptr, output one-hot gnt, parameterised by NUM_REQ.
REQ-033 RTL target is 120-400 lines, with no memories beyond buf.

Verification
REQ-034 Warm-up: reset, smp_valid_i=1 every cycle, req_i=4'b1111, WARMUP=64.
- No gnt_o for the first 64 transfers; busy_o falls after the 64th.
- First grant is gnt_o=4'b0001 with data_o equal to the 65th sample.
REQ-035 Round-robin: SERVE, req_i=4'b1111 held, continuous samples.
- gnt_o sequence 0001,0010,0100,1000,0001 on consecutive cycles.
- grant_cnt_o increments by 1 per cycle.
REQ-036 Pointer skip and wrap: ptr=3, req_i=4'b0101.
- Grant goes to index 0 (0001), then index 2 (0100).
REQ-037 Backpressure: req_i=0 for 10 cycles with smp_valid_i=1.
- One sample accepted, then smp_ready_o=0; buf is unchanged.
- With req_i=4'b0010 next, gnt_o=0010 with data_o equal to that held sample.
REQ-038 Flush mid-operation: SERVE with buf_vld=1 and req_i=4'b1111, assert flush_i for 1 cycle.
- That cycle gnt_o=0 and smp_ready_o=0.
- Next cycle busy_o=1, grant_cnt_o=0 and ptr=0; 64 new discards follow before the next grant.
REQ-039 Async reset mid-grant: assert rst_i between clock edges.
- gnt_o, data_o and grant_cnt_o go to 0 immediately, without waiting for a clock edge.
